vga_frame_fetch: RTL and testbench
==================================

Name: vga_frame_fetch

Overview:
Parametrised video-frame prefetch engine for the VGA core. It replaces the open-loop read path, which fires a strobe per pixel fetch and ignores ack. This block walks a 2-D frame (line base plus stride) in video RAM as a proper Wishbone master that honours ack. Fetched words are buffered in a synchronous FIFO that the pixel pipeline drains, giving stall tolerance, burst fetches, programmable stride and underflow detection. Sits between the config registers and the video RAM arbiter, on the Wishbone clock.

Parameters:
AW, 17, word-address width of video RAM (wbm_adr_o spans [AW:1])
DW, 16, data width
DEPTH, 16, FIFO depth in words, power of two, >= 2*BURST
BURST, 4, maximum words per Wishbone cycle (cyc held across the burst)
LW, 10, width of words-per-line and lines-per-frame counts

Ports:
wb_clk_i  in  1  system clock; single clock domain
wb_rst_i  in  1  synchronous reset, active high
start_addr  in  AW  frame base word address; sampled on frame_start
line_stride  in  AW  word distance between line bases; sampled on frame_start
words_per_line  in  LW  words fetched per line (0 = no fetch, frame_done immediately)
lines_per_frame  in  LW  lines per frame (0 = frame_done immediately)
frame_start  in  1  one-cycle pulse: flush and restart at start_addr
rd_en  in  1  consumer pop request
rd_dat  out  DW  FIFO head word; valid while rd_valid
rd_valid  out  1  FIFO not empty
underflow  out  1  sticky: rd_en seen while rd_valid=0
frame_done  out  1  level: all words of the frame pushed into FIFO
wbm_adr_o  out  AW  master address [AW:1]
wbm_dat_o  out  DW  constant 0 (read-only master)
wbm_dat_i  in  DW  read data
wbm_sel_o  out  2  constant 2'b11
wbm_we_o  out  1  constant 0
wbm_stb_o  out  1  strobe
wbm_cyc_o  out  1  cycle
wbm_ack_i  in  1  acknowledge

Behaviour:
- Reset values: stb=0, cyc=0, adr=0, rd_valid=0, underflow=0, frame_done=1, FIFO empty, state IDLE.
- States:
  - IDLE: wait for frame_start.
  - REQ: cyc=1, stb=1 held until ack.
  - GAP: cyc=0, waiting for FIFO space.
  - DISCARD: finish an in-flight word after a restart, dropping its data.
  - DONE: frame_done=1, wait for frame_start.
- frame_start in IDLE, GAP or DONE:
  - Next cycle: FIFO flushed; line_base=adr=start_addr; word_cnt=line_cnt=0; underflow=0; frame_done=0.
  - Enter REQ if FIFO space allows, else GAP.
  - stb rises one cycle after frame_start.
- frame_start in REQ:
  - Keep stb/cyc asserted until ack; the acked word is not pushed (DISCARD).
  - Then flush and restart as above.
  - A second frame_start during DISCARD only re-samples start_addr and line_stride.
- Burst issue rule: from GAP, enter REQ only when free >= min(BURST, words remaining in frame).
  - free = DEPTH - count, where count includes the word in flight.
- In REQ, each ack:
  - Pushes wbm_dat_i.
  - Increments word_cnt and adr in the same cycle; stb stays high for the next word (next address presented the cycle after ack).
  - The burst ends (cyc and stb drop for at least one cycle, state GAP) after BURST acks, at end of line, or at end of frame.
- End of line (word_cnt reaches words_per_line on ack):
  - line_base += line_stride, adr = new line_base, word_cnt=0, line_cnt++.
  - Last line goes to DONE.
- Address arithmetic is modulo 2^AW; wrap past the top of RAM is legal and silent.
- No ack: the master waits indefinitely. No timeout.
- FIFO is first-word-fall-through:
  - A push on cycle N makes rd_valid=1 at N+1.
  - Pop occurs when rd_en & rd_valid.
  - Simultaneous push and pop leaves count unchanged and is legal at full or empty-with-incoming.
- rd_en with rd_valid=0 sets underflow; it has no FIFO effect.
- Push never occurs when full; guaranteed by the issue rule and checked by assertion.
- Reset mid-burst drops stb and cyc in the next cycle regardless of ack.

Decomposition:
- Package vga_pkg: state enum (IDLE, REQ, GAP, DISCARD, DONE) and constant WB_SEL_ALL=2'b11.
- Sub-module vga_sync_fifo (DW, DEPTH): synchronous FWFT FIFO with count, flush, push, pop.
- The FSM, address and line counters stay in vga_frame_fetch.

Test Plan:
- Linear frame: start_addr=0x100, stride=4, words=4, lines=3, ack every cycle, rd_en=1 → addresses 0x100–0x10B in order; 12 words out in order; frame_done=1; underflow=0.
- Stride and wrap: start_addr=0x1FFFE, stride=0x10, words=4, lines=2 → addresses 1FFFE, 1FFFF, 00000, 00001, then 0000E…00011.
- Backpressure: DEPTH=16, BURST=4, rd_en=0, frame of 40 words → stops at exactly 16 words with cyc=0; each 4 pops resume one 4-word burst.
- Restart mid-cycle: frame_start while stb=1 and ack delayed 3 cycles → acked word not in FIFO; FIFO empty; the first new address equals the new start_addr.
- Underflow: rd_en=1 immediately after frame_start → underflow=1 until the next frame_start; data order intact.
- Random ack latency 0–5 cycles with random rd_en → scoreboard matches the RAM model for 3 consecutive frames; no push when full.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types for the VGA frame prefetch engine.
// Fetch FSM states and fixed Wishbone select.
package vga_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    DISCARD,
    DONE
  } state_t;

  localparam logic [1:0] WB_SEL_ALL = 2'b11;

endpackage

// File: rtl/vga_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Head word is visible on dout while valid.
module vga_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   cnt;
  logic          do_pop;

  assign do_pop = pop && (cnt != '0);
  assign dout   = mem[rptr];
  assign valid  = (cnt != '0);
  assign count  = cnt;

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // Pointer and occupancy tracking; flush empties in one cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      unique case ({push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst || flush)
    !(push && !do_pop && cnt == FULL)
  );

endmodule

// File: rtl/vga_frame_fetch.sv
// Frame prefetch: walks line base + stride in video
// RAM as a Wishbone master and buffers words in a FIFO.
module vga_frame_fetch
  import vga_pkg::*;
#(
  parameter int AW    = 17,
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int BURST = 4,
  parameter int LW    = 10
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] line_stride,
  input  logic [LW-1:0] words_per_line,
  input  logic [LW-1:0] lines_per_frame,
  input  logic          frame_start,
  input  logic          rd_en,
  output logic [DW-1:0] rd_dat,
  output logic          rd_valid,
  output logic          underflow,
  output logic          frame_done,
  output logic [AW-1:0] wbm_adr_o,
  output logic [DW-1:0] wbm_dat_o,
  input  logic [DW-1:0] wbm_dat_i,
  output logic [1:0]    wbm_sel_o,
  output logic          wbm_we_o,
  output logic          wbm_stb_o,
  output logic          wbm_cyc_o,
  input  logic          wbm_ack_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int RW = 2 * LW;
  localparam int BW = $clog2(BURST + 1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] adr;
  logic [AW-1:0] line_base;
  logic [AW-1:0] next_base;
  logic [AW-1:0] start_q;
  logic [AW-1:0] stride_q;
  logic [LW-1:0] wpl_q;
  logic [LW-1:0] lpf_q;
  logic [LW-1:0] word_cnt;
  logic [LW-1:0] line_cnt;
  logic [RW-1:0] rem;
  logic [RW-1:0] need;
  logic [BW-1:0] burst_cnt;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          room;
  logic          restart;
  logic          take_ack;
  logic          eol;
  logic          eof;
  logic          burst_end;
  logic          pop;
  logic [AW-1:0] rs_start;
  logic [AW-1:0] rs_stride;
  logic [LW-1:0] rs_wpl;
  logic [LW-1:0] rs_lpf;

  assign wbm_adr_o  = adr;
  assign wbm_dat_o  = '0;
  assign wbm_sel_o  = WB_SEL_ALL;
  assign wbm_we_o   = 1'b0;
  assign wbm_stb_o  = (state == REQ) || (state == DISCARD);
  assign wbm_cyc_o  = wbm_stb_o;
  assign frame_done = (state == IDLE) || (state == DONE);

  assign next_base = line_base + stride_q;
  assign eol       = (LW'(word_cnt + 1'b1) == wpl_q);
  assign eof       = eol && (LW'(line_cnt + 1'b1) == lpf_q);
  assign burst_end = (burst_cnt == BW'(BURST - 1));

  // Issue a burst only when the whole of it is sure to fit.
  assign free = CW'(DEPTH) - count;
  assign need = (rem < RW'(BURST)) ? rem : RW'(BURST);
  assign room = (RW'(free) >= need);

  // A restart from DISCARD reuses geometry captured earlier.
  assign rs_start  = frame_start ? start_addr : start_q;
  assign rs_stride = frame_start ? line_stride : stride_q;
  assign rs_wpl    = (state == DISCARD) ? wpl_q : words_per_line;
  assign rs_lpf    = (state == DISCARD) ? lpf_q : lines_per_frame;

  assign pop = rd_en && rd_valid;

  // Next state and restart/accept decisions.
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    take_ack = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (frame_start) restart = 1'b1;
      end
      GAP: begin
        if (frame_start) restart = 1'b1;
        else if (room)   state_nx = REQ;
      end
      REQ: begin
        if (frame_start) begin
          if (wbm_ack_i) restart  = 1'b1;
          else           state_nx = DISCARD;
        end else if (wbm_ack_i) begin
          take_ack = 1'b1;
          if (eof)                   state_nx = DONE;
          else if (eol || burst_end) state_nx = GAP;
        end
      end
      DISCARD: begin
        if (wbm_ack_i) restart = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (restart) begin
      state_nx = (rs_wpl == '0 || rs_lpf == '0) ? DONE : REQ;
    end
  end

  // State, address walk, counters and sticky underflow.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      adr       <= '0;
      line_base <= '0;
      start_q   <= '0;
      stride_q  <= '0;
      wpl_q     <= '0;
      lpf_q     <= '0;
      word_cnt  <= '0;
      line_cnt  <= '0;
      rem       <= '0;
      burst_cnt <= '0;
      underflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (restart || state != REQ) burst_cnt <= '0;
      else if (take_ack)           burst_cnt <= burst_cnt + 1'b1;
      if (restart) begin
        adr       <= rs_start;
        line_base <= rs_start;
        stride_q  <= rs_stride;
        wpl_q     <= rs_wpl;
        lpf_q     <= rs_lpf;
        word_cnt  <= '0;
        line_cnt  <= '0;
        rem       <= RW'(rs_wpl) * RW'(rs_lpf);
        underflow <= 1'b0;
      end else begin
        if (frame_start && (state == REQ || state == DISCARD)) begin
          start_q  <= start_addr;
          stride_q <= line_stride;
        end
        if (frame_start && state == REQ) begin
          wpl_q <= words_per_line;
          lpf_q <= lines_per_frame;
        end
        if (take_ack) begin
          rem <= rem - 1'b1;
          if (eol) begin
            line_base <= next_base;
            adr       <= next_base;
            word_cnt  <= '0;
            line_cnt  <= line_cnt + 1'b1;
          end else begin
            adr      <= adr + 1'b1;
            word_cnt <= word_cnt + 1'b1;
          end
        end
        if (rd_en && !rd_valid) underflow <= 1'b1;
      end
    end
  end

  vga_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .flush (restart),
    .push  (take_ack),
    .pop   (pop),
    .din   (wbm_dat_i),
    .dout  (rd_dat),
    .valid (rd_valid),
    .count (count)
  );

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Bench for vga_frame_fetch: table of frames plus
// hand sequences for backpressure, restart and reset.
module tb_vga_frame_fetch;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [16:0] start_addr;
  logic [16:0] line_stride;
  logic [9:0]  words_per_line;
  logic [9:0]  lines_per_frame;
  logic        frame_start;
  logic        rd_en;
  logic [15:0] rd_dat;
  logic        rd_valid;
  logic        underflow;
  logic        frame_done;
  logic [16:0] wbm_adr_o;
  logic [15:0] wbm_dat_o;
  logic [15:0] wbm_dat_i;
  logic [1:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;

  always #5 wb_clk_i = ~wb_clk_i;

  vga_frame_fetch dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_i        (wb_rst_i),
    .start_addr      (start_addr),
    .line_stride     (line_stride),
    .words_per_line  (words_per_line),
    .lines_per_frame (lines_per_frame),
    .frame_start     (frame_start),
    .rd_en           (rd_en),
    .rd_dat          (rd_dat),
    .rd_valid        (rd_valid),
    .underflow       (underflow),
    .frame_done      (frame_done),
    .wbm_adr_o       (wbm_adr_o),
    .wbm_dat_o       (wbm_dat_o),
    .wbm_dat_i       (wbm_dat_i),
    .wbm_sel_o       (wbm_sel_o),
    .wbm_we_o        (wbm_we_o),
    .wbm_stb_o       (wbm_stb_o),
    .wbm_cyc_o       (wbm_cyc_o),
    .wbm_ack_i       (wbm_ack_i)
  );

  typedef struct {
    logic [16:0] start;
    logic [16:0] stride;
    logic [9:0]  wpl;
    logic [9:0]  lpf;
    bit          rnd;
    int          lat;
    int          rd;
    int          n;
    logic [16:0] first;
    logic [16:0] last;
    bit          uf;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  logic [16:0] adr_log[$];
  logic [15:0] got[$];
  bit          rnd_lat;
  int          fix_lat;
  int          rd_mode;
  int          pop_budget;
  bit          busy;
  int          waitc;
  int          cur_lat;

  function automatic logic [15:0] ramf(input logic [16:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[16], 15'd0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge wb_clk_i);
      #1;
    end
  endtask

  // Wishbone slave with programmable latency and the pixel consumer.
  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    rd_en     = 1'b0;
    busy      = 1'b0;
    waitc     = 0;
    cur_lat   = 0;
    forever begin
      @(negedge wb_clk_i);
      wbm_ack_i = 1'b0;
      if (wb_rst_i || !(wbm_cyc_o && wbm_stb_o)) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy    = 1'b1;
          waitc   = 0;
          cur_lat = rnd_lat ? int'($urandom_range(0, 5)) : fix_lat;
        end
        if (waitc >= cur_lat) begin
          wbm_ack_i = 1'b1;
          wbm_dat_i = ramf(wbm_adr_o);
          adr_log.push_back(wbm_adr_o);
          busy = 1'b0;
        end else begin
          waitc++;
        end
      end
      case (rd_mode)
        1: rd_en = 1'b1;
        2: rd_en = rd_valid;
        3: rd_en = rd_valid && ($urandom_range(0, 1) == 1);
        4: begin
          rd_en = rd_valid && (pop_budget > 0);
          if (rd_en) pop_budget--;
        end
        default: rd_en = 1'b0;
      endcase
      if (rd_en && rd_valid && !wb_rst_i) got.push_back(rd_dat);
    end
  end

  task automatic pulse_start(input logic [16:0] s, input logic [16:0] st,
                             input logic [9:0] w, input logic [9:0] l);
    start_addr      = s;
    line_stride     = st;
    words_per_line  = w;
    lines_per_frame = l;
    frame_start     = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int n);
    int i;
    i = 0;
    while (i < 4000 && !(frame_done && got.size() == n)) begin
      tick();
      i++;
    end
    chk(nm, i < 4000, 1);
    tick(4);
  endtask

  task automatic run_vec(input vec_t v);
    logic [16:0] e[$];
    int mism;
    adr_log.delete();
    got.delete();
    rnd_lat = v.rnd;
    fix_lat = v.lat;
    rd_mode = v.rd;
    pulse_start(v.start, v.stride, v.wpl, v.lpf);
    chk("fs_done", frame_done, v.n == 0);
    chk("fs_stb", wbm_stb_o, v.n != 0);
    chk("fs_adr", wbm_adr_o, v.start);
    for (int l = 0; l < int'(v.lpf); l++)
      for (int w = 0; w < int'(v.wpl); w++)
        e.push_back(v.start + v.stride * 17'(l) + 17'(w));
    wait_drain("vec_timeout", v.n);
    chk("n_adr", adr_log.size(), v.n);
    chk("n_dat", got.size(), v.n);
    if (v.n > 0 && adr_log.size() > 0) begin
      chk("first_adr", adr_log[0], v.first);
      chk("last_adr", adr_log[adr_log.size()-1], v.last);
    end
    mism = 0;
    for (int j = 0; j < e.size(); j++) begin
      if (j >= adr_log.size() || adr_log[j] !== e[j]) mism++;
      if (j >= got.size() || got[j] !== ramf(e[j])) mism++;
    end
    chk("seq", mism, 0);
    chk("uf", underflow, v.uf);
    chk("end_cyc", wbm_cyc_o, 0);
    chk("end_done", frame_done, 1);
    chk("end_valid", rd_valid, 0);
  endtask

  vec_t vt[7];
  int   order[7] = '{0, 1, 3, 4, 2, 5, 6};

  initial begin
    int i;
    int mism;
    vt[0] = '{17'h00100, 17'h4, 10'd4, 10'd3, 1'b0, 0, 2, 12,
              17'h00100, 17'h0010B, 1'b0};
    vt[1] = '{17'h1FFFE, 17'h10, 10'd4, 10'd2, 1'b0, 0, 2, 8,
              17'h1FFFE, 17'h00011, 1'b0};
    vt[2] = '{17'h02000, 17'h40, 10'd5, 10'd3, 1'b1, 0, 3, 15,
              17'h02000, 17'h02084, 1'b0};
    vt[3] = '{17'h00000, 17'h7, 10'd3, 10'd4, 1'b0, 2, 1, 12,
              17'h00000, 17'h00017, 1'b1};
    vt[4] = '{17'h00400, 17'h4, 10'd0, 10'd5, 1'b0, 0, 2, 0,
              17'h00000, 17'h00000, 1'b0};
    vt[5] = '{17'h1FFF0, 17'h1000, 10'd6, 10'd3, 1'b1, 0, 3, 18,
              17'h1FFF0, 17'h01FF5, 1'b0};
    vt[6] = '{17'h00300, 17'h2, 10'd8, 10'd2, 1'b1, 0, 3, 16,
              17'h00300, 17'h00309, 1'b0};

    wb_rst_i        = 1'b1;
    frame_start     = 1'b0;
    start_addr      = '0;
    line_stride     = '0;
    words_per_line  = '0;
    lines_per_frame = '0;
    rnd_lat         = 1'b0;
    fix_lat         = 0;
    rd_mode         = 0;
    pop_budget      = 0;
    tick(3);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_done", frame_done, 1);
    chk("rst_sel", wbm_sel_o, 2'b11);
    chk("rst_we", wbm_we_o, 0);
    chk("rst_dato", wbm_dat_o, 0);
    wb_rst_i = 1'b0;
    tick(2);

    foreach (order[k]) run_vec(vt[order[k]]);

    // Backpressure: 40-word frame with no reads stops at 16.
    adr_log.delete();
    got.delete();
    rnd_lat = 1'b0;
    fix_lat = 0;
    rd_mode = 0;
    pulse_start(17'h00500, 17'h8, 10'd8, 10'd5);
    tick(40);
    chk("bp_fill", adr_log.size(), 16);
    chk("bp_cyc", wbm_cyc_o, 0);
    chk("bp_valid", rd_valid, 1);
    pop_budget = 3;
    rd_mode    = 4;
    tick(15);
    chk("bp_pop3", adr_log.size(), 16);
    pop_budget = 1;
    tick(15);
    chk("bp_pop4", adr_log.size(), 20);
    chk("bp_cyc2", wbm_cyc_o, 0);
    chk("bp_ngot", got.size(), 4);
    rd_mode = 2;
    wait_drain("bp_timeout", 40);
    chk("bp_nadr", adr_log.size(), 40);
    chk("bp_ndat", got.size(), 40);
    mism = 0;
    for (int j = 0; j < 40; j++) begin
      if (j >= adr_log.size() || adr_log[j] !== 17'h00500 + 17'(j)) mism++;
      if (j >= got.size() || got[j] !== ramf(17'h00500 + 17'(j))) mism++;
    end
    chk("bp_seq", mism, 0);
    chk("bp_uf", underflow, 0);

    // Restart while a word is outstanding; second pulse re-aims base only.
    adr_log.delete();
    got.delete();
    fix_lat = 0;
    rd_mode = 0;
    pulse_start(17'h00700, 17'h8, 10'd8, 10'd2);
    i = 0;
    while (i < 100 && adr_log.size() < 4) begin
      tick();
      i++;
    end
    chk("rs_first_to", i < 100, 1);
    fix_lat = 3;
    tick();
    i = 0;
    while (i < 100 && !wbm_stb_o) begin
      tick();
      i++;
    end
    chk("rs_stb_to", i < 100, 1);
    start_addr      = 17'h00900;
    line_stride     = 17'h4;
    words_per_line  = 10'd4;
    lines_per_frame = 10'd1;
    frame_start     = 1'b1;
    tick();
    start_addr     = 17'h00A00;
    words_per_line = 10'd6;
    tick();
    frame_start = 1'b0;
    chk("rs_hold_stb", wbm_stb_o, 1);
    chk("rs_old_valid", rd_valid, 1);
    i = 0;
    while (i < 100 && adr_log.size() < 5) begin
      tick();
      i++;
    end
    chk("rs_ack_to", i < 100, 1);
    if (adr_log.size() >= 5) chk("rs_acked", adr_log[4], 17'h00704);
    tick();
    chk("rs_flushed", rd_valid, 0);
    chk("rs_new_adr", wbm_adr_o, 17'h00A00);
    chk("rs_stb", wbm_stb_o, 1);
    chk("rs_done", frame_done, 0);
    chk("rs_uf", underflow, 0);
    adr_log.delete();
    got.delete();
    fix_lat = 0;
    rd_mode = 2;
    wait_drain("rs_timeout", 4);
    chk("rs_nadr", adr_log.size(), 4);
    chk("rs_ndat", got.size(), 4);
    mism = 0;
    for (int j = 0; j < 4; j++) begin
      if (j >= adr_log.size() || adr_log[j] !== 17'h00A00 + 17'(j)) mism++;
      if (j >= got.size() || got[j] !== ramf(17'h00A00 + 17'(j))) mism++;
    end
    chk("rs_seq", mism, 0);

    // Reset in the middle of a burst.
    adr_log.delete();
    got.delete();
    fix_lat = 3;
    rd_mode = 0;
    pulse_start(17'h00B00, 17'h4, 10'd4, 10'd2);
    tick(2);
    chk("mr_pre_stb", wbm_stb_o, 1);
    wb_rst_i = 1'b1;
    tick();
    chk("mr_stb", wbm_stb_o, 0);
    chk("mr_cyc", wbm_cyc_o, 0);
    chk("mr_adr", wbm_adr_o, 0);
    chk("mr_done", frame_done, 1);
    wb_rst_i = 1'b0;
    tick(3);
    chk("mr_idle_stb", wbm_stb_o, 0);
    chk("mr_idle_valid", rd_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
